// File: rtl/mode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mode_ctrl_pkg
// Purpose  : Shared definitions for the mode controller: processing-mode
//            encodings, mode word width and the button-FSM state type.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mode_ctrl_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_INV        = 3'd0;
  localparam logic [MODE_W-1:0] MODE_INV_DIM    = 3'd1;
  localparam logic [MODE_W-1:0] MODE_YINV       = 3'd2;
  localparam logic [MODE_W-1:0] MODE_INV_OR_DIM = 3'd3;
  localparam logic [MODE_W-1:0] MODE_SHIFT_DIM  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_DIM_DEEP   = 3'd5;
  localparam logic [MODE_W-1:0] MODE_DIM        = 3'd6;
  localparam logic [MODE_W-1:0] MODE_PASS       = 3'd7;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_HELD    = 2'd2
  } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/mode_ctrl_btn_press.sv
`default_nettype none
// ============================================================================
// Module   : btn_press
// Purpose  : One push-button front end: 2-flop synchroniser, debounce and
//            short/long press classifier.
// Ports    : clk_i    - clock
//            rst_ni   - asynchronous active-low reset
//            btn_i    - raw button, active-high, asynchronous
//            short_o  - 1-cycle pulse on release before the long threshold
//            long_o   - 1-cycle pulse when the hold reaches the long threshold
// Revision : 1.0  initial release
// ============================================================================
module btn_press
  import mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 100000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic short_o,
  output logic long_o
);

  localparam int c_db_w   = $clog2(DEBOUNCE_CYC);
  localparam int c_hold_w = $clog2(LONG_CYC);
  localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYC - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_CYC - 1);

  logic [1:0]          r_sync;
  logic                r_deb;
  logic [c_db_w-1:0]   r_db_cnt;
  btn_state_t          r_state;
  btn_state_t          w_state_nxt;
  logic [c_hold_w-1:0] r_hold;
  logic [c_hold_w-1:0] w_hold_nxt;

  // Synchroniser and debounce: the level only flips after the synchronised
  // input has disagreed with it for DEBOUNCE_CYC consecutive cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync   <= 2'b00;
      r_deb    <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], btn_i};
      if (r_sync[1] == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_last) begin
        r_deb    <= ~r_deb;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= BTN_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // The debounced level can only go high from IDLE via a rise, so testing
  // the level in IDLE is equivalent to edge detection. The hold counter
  // stops at its threshold, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    short_o     = 1'b0;
    long_o      = 1'b0;
    case (r_state)
      BTN_IDLE: begin
        if (r_deb) begin
          w_state_nxt = BTN_PRESSED;
          w_hold_nxt  = '0;
        end
      end
      BTN_PRESSED: begin
        if (!r_deb) begin
          short_o     = 1'b1;
          w_state_nxt = BTN_IDLE;
        end else if (r_hold == c_hold_last) begin
          long_o      = 1'b1;
          w_state_nxt = BTN_HELD;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      BTN_HELD: begin
        if (!r_deb) begin
          w_state_nxt = BTN_IDLE;
        end
      end
      default: begin
        w_state_nxt = BTN_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mode_ctrl
// Purpose  : Processing-mode selector. Two buttons step a pending mode
//            (short press) or restore the default (long press); the pending
//            mode is committed to mode_o only at a vertical-sync rising edge.
// Ports    : vin_clk_i  - pixel clock
//            rst_ni     - asynchronous active-low reset
//            btn_next_i - raw "next mode" button
//            btn_prev_i - raw "previous mode" button
//            vin_vs_i   - vertical sync, active-high
//            mode_o     - committed mode word
//            pending_o  - high while the pending mode differs from mode_o
// Revision : 1.0  initial release
// ============================================================================
module mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 100000000,
  parameter int NMODES       = 8,
  parameter int DEFAULT_MODE = 7
) (
  input  logic              vin_clk_i,
  input  logic              rst_ni,
  input  logic              btn_next_i,
  input  logic              btn_prev_i,
  input  logic              vin_vs_i,
  output logic [MODE_W-1:0] mode_o,
  output logic              pending_o
);

  localparam logic [MODE_W-1:0] c_last_mode    = MODE_W'(NMODES - 1);
  localparam logic [MODE_W-1:0] c_default_mode = MODE_W'(DEFAULT_MODE);

  logic              w_short_next;
  logic              w_long_next;
  logic              w_short_prev;
  logic              w_long_prev;
  logic              r_vs_q;
  logic              w_vs_rise;
  logic [MODE_W-1:0] r_pending;
  logic [MODE_W-1:0] w_pending_nxt;
  logic [MODE_W-1:0] r_mode;
  logic [MODE_W-1:0] w_mode_nxt;
  logic              r_pend_flag;

  btn_press #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .LONG_CYC     (LONG_CYC)
  ) u_btn_next (
    .clk_i   (vin_clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (btn_next_i),
    .short_o (w_short_next),
    .long_o  (w_long_next)
  );

  btn_press #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .LONG_CYC     (LONG_CYC)
  ) u_btn_prev (
    .clk_i   (vin_clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (btn_prev_i),
    .short_o (w_short_prev),
    .long_o  (w_long_prev)
  );

  assign w_vs_rise = vin_vs_i & ~r_vs_q;

  // Wrap is an explicit compare against the last legal mode so that
  // NMODES < 8 never produces an out-of-range mode word.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_long_next || w_long_prev) begin
      w_pending_nxt = c_default_mode;
    end else if (w_short_next && w_short_prev) begin
      w_pending_nxt = r_pending;
    end else if (w_short_next) begin
      w_pending_nxt = (r_pending == c_last_mode) ? '0 : r_pending + 1'b1;
    end else if (w_short_prev) begin
      w_pending_nxt = (r_pending == '0) ? c_last_mode : r_pending - 1'b1;
    end
  end

  // Commit samples the pending value held before any same-cycle update.
  assign w_mode_nxt = w_vs_rise ? r_pending : r_mode;

  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vs_q      <= 1'b0;
      r_pending   <= c_default_mode;
      r_mode      <= c_default_mode;
      r_pend_flag <= 1'b0;
    end else begin
      r_vs_q      <= vin_vs_i;
      r_pending   <= w_pending_nxt;
      r_mode      <= w_mode_nxt;
      // Built from next-state values so the flag tracks the registers
      // without an extra cycle of lag.
      r_pend_flag <= (w_pending_nxt != w_mode_nxt);
    end
  end

  assign mode_o    = r_mode;
  assign pending_o = r_pend_flag;

endmodule
`default_nettype wire

// File: tb/tb_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_ctrl
// Purpose  : Directed self-checking bench for mode_ctrl with short debounce
//            and long-press thresholds.
// Revision : 1.0  initial release
// ============================================================================
module tb_mode_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic       clk;
  logic       rst_n;
  logic       btn_next;
  logic       btn_prev;
  logic       vs;
  logic [2:0] mode;
  logic       pend;

  int n_checks;
  int n_errors;
  int n_short_next;
  int n_short_prev;
  int n_long;
  int sn0, sp0, lg0;

  mode_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .LONG_CYC     (LONG),
    .NMODES       (8),
    .DEFAULT_MODE (7)
  ) dut (
    .vin_clk_i  (clk),
    .rst_ni     (rst_n),
    .btn_next_i (btn_next),
    .btn_prev_i (btn_prev),
    .vin_vs_i   (vs),
    .mode_o     (mode),
    .pending_o  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters observed at the edge that consumes the pulse.
  always @(posedge clk) begin
    if (rst_n) begin
      if (dut.u_btn_next.short_o) n_short_next <= n_short_next + 1;
      if (dut.u_btn_prev.short_o) n_short_prev <= n_short_prev + 1;
      if (dut.u_btn_next.long_o || dut.u_btn_prev.long_o) n_long <= n_long + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic nxt, input logic prv, input int hold);
    btn_next = nxt;
    btn_prev = prv;
    cyc(hold);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cyc(20);
  endtask

  task automatic frame();
    vs = 1'b1;
    cyc(1);
    vs = 1'b0;
    cyc(3);
  endtask

  task automatic snap();
    sn0 = n_short_next;
    sp0 = n_short_prev;
    lg0 = n_long;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    n_short_next = 0; n_short_prev = 0; n_long = 0;
    btn_next = 1'b0; btn_prev = 1'b0; vs = 1'b0; rst_n = 1'b0;
    cyc(3);
    check("reset_mode", 32'(mode), 32'd7);
    check("reset_pending", 32'(pend), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Idle frame.
    frame();
    check("idle_mode", 32'(mode), 32'd7);
    check("idle_pending", 32'(pend), 32'd0);

    // Short next: 7 -> 0, commit exactly one cycle after vs rises.
    press(1'b1, 1'b0, 8);
    check("next_pending_flag", 32'(pend), 32'd1);
    check("next_mode_before_vs", 32'(mode), 32'd7);
    vs = 1'b1;
    check("mode_during_vs_rise", 32'(mode), 32'd7);
    cyc(1);
    check("mode_after_vs", 32'(mode), 32'd0);
    check("pending_flag_cleared", 32'(pend), 32'd0);
    vs = 1'b0;
    cyc(3);

    // 3-cycle glitch is filtered.
    snap();
    press(1'b1, 1'b0, 3);
    check("glitch_no_pulse", 32'(n_short_next - sn0), 32'd0);
    check("glitch_pending_flag", 32'(pend), 32'd0);
    frame();
    check("glitch_mode", 32'(mode), 32'd0);

    // prev (0->7), then two next (7->0->1) within one frame.
    press(1'b0, 1'b1, 8);
    check("prev_wrap_flag", 32'(pend), 32'd1);
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    check("accum_mode_held", 32'(mode), 32'd0);
    check("accum_pending_flag", 32'(pend), 32'd1);
    frame();
    check("accum_commit", 32'(mode), 32'd1);

    // Reach mode 3, then a long hold restores the default.
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    frame();
    check("mode3", 32'(mode), 32'd3);
    snap();
    btn_next = 1'b1;
    cyc(25);
    check("long_not_yet", 32'(dut.u_btn_next.long_o), 32'd0);
    cyc(1);
    check("long_at_19", 32'(dut.u_btn_next.long_o), 32'd1);
    check("long_while_held", 32'(btn_next), 32'd1);
    cyc(1);
    check("long_one_cycle", 32'(dut.u_btn_next.long_o), 32'd0);
    cyc(3);
    btn_next = 1'b0;
    cyc(20);
    check("long_count", 32'(n_long - lg0), 32'd1);
    check("long_no_short", 32'(n_short_next - sn0), 32'd0);
    check("long_pending_flag", 32'(pend), 32'd1);
    frame();
    check("long_commit", 32'(mode), 32'd7);

    // Simultaneous short next and prev: no change.
    snap();
    press(1'b1, 1'b1, 8);
    check("both_next_fired", 32'(n_short_next - sn0), 32'd1);
    check("both_prev_fired", 32'(n_short_prev - sp0), 32'd1);
    check("both_no_change", 32'(pend), 32'd0);
    frame();
    check("both_mode", 32'(mode), 32'd7);

    // Press completing in the vs_rise cycle commits the old pending value.
    btn_next = 1'b1;
    cyc(8);
    btn_next = 1'b0;
    cyc(6);
    check("aligned_short", 32'(dut.u_btn_next.short_o), 32'd1);
    vs = 1'b1;
    cyc(1);
    vs = 1'b0;
    check("aligned_old_commit", 32'(mode), 32'd7);
    check("aligned_flag", 32'(pend), 32'd1);
    cyc(20);
    frame();
    check("aligned_next_frame", 32'(mode), 32'd0);

    // Reset mid-hold.
    snap();
    btn_next = 1'b1;
    cyc(10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mode", 32'(mode), 32'd7);
    check("rst_mid_flag", 32'(pend), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    btn_next = 1'b0;
    cyc(20);
    check("rst_no_short", 32'(n_short_next - sn0), 32'd0);
    check("rst_no_long", 32'(n_long - lg0), 32'd0);
    check("rst_flag_after", 32'(pend), 32'd0);
    frame();
    check("rst_mode_after", 32'(mode), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
